// File: rtl/ssd_image_ram.sv
// Single-port Avalon-MM image buffer with byte enables, pipelined reads and waitrequest flow control.
// Define SSD_IMGRAM_CLEAR_EN to build the post-reset zero-fill sweep; otherwise the array is preloaded from INIT_FILE.
module ssd_image_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 58368,
    parameter int ADDR_WIDTH = 16,
    parameter int OUT_REG    = 0,
    parameter     INIT_FILE  = "ssd_image_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest,
    output logic                    init_done
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

`ifdef SSD_IMGRAM_CLEAR_EN
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`else
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];
`endif

    logic                  inRange;
    logic                  accept;
    logic                  wrAccept;
    logic                  rdAccept;
    logic [IDX_W-1:0]      memIdx;
    logic [DATA_WIDTH-1:0] rdWord;
    logic                  rdValid_q;
    logic [DATA_WIDTH-1:0] rdData_q;

    assign inRange     = ({1'b0, address} < DEPTH_W);
    assign memIdx      = address[IDX_W-1:0];
    assign waitrequest = ~init_done | ~clken | reset_req;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    // A simultaneous read+write is treated purely as a write.
    assign wrAccept    = accept & write;
    assign rdAccept    = accept & read & ~write;
    assign rdWord      = inRange ? mem_q[memIdx] : '0;

`ifdef SSD_IMGRAM_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] clrAddr_q, clrAddr_d;
    logic             clearWr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clrAddr_q <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        clearWr   = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clken && !reset_req) begin
                    clearWr = 1'b1;
                    if (clrAddr_q == IDX_W'(DEPTH - 1)) begin
                        state_d = READY;
                    end else begin
                        clrAddr_d = clrAddr_q + 1'b1;
                    end
                end
            end
            READY:   state_d = READY;
            default: state_d = READY;
        endcase
    end

    assign init_done = (state_q == READY);

    always_ff @(posedge clk) begin
        if (clearWr) begin
            mem_q[clrAddr_q] <= '0;
        end else if (wrAccept && inRange) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byteenable[i]) mem_q[memIdx][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end
`else
    assign init_done = 1'b1;

    always_ff @(posedge clk) begin
        if (wrAccept && inRange) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byteenable[i]) mem_q[memIdx][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end
`endif

    // Read pipeline runs ungated so reads already accepted always complete.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdValid_q <= 1'b0;
            rdData_q  <= '0;
        end else begin
            rdValid_q <= rdAccept;
            if (rdAccept) rdData_q <= rdWord;
        end
    end

    if (OUT_REG != 0) begin : g_outReg
        logic                  outValid_q;
        logic [DATA_WIDTH-1:0] outData_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                outValid_q <= 1'b0;
                outData_q  <= '0;
            end else begin
                outValid_q <= rdValid_q;
                if (rdValid_q) outData_q <= rdData_q;
            end
        end

        assign readdatavalid = outValid_q;
        assign readdata      = outData_q;
    end else begin : g_noOutReg
        assign readdatavalid = rdValid_q;
        assign readdata      = rdData_q;
    end

endmodule

// File: tb/tb_ssd_image_ram.sv
// Randomized self-checking bench for ssd_image_ram: two instances (OUT_REG=0 and 1) share stimulus
// and are compared against an address-keyed memory model with per-cycle expected read returns.
`timescale 1ns/1ps
module tb_ssd_image_ram;

    localparam int DW = 32;
    localparam int AW = 16;
`ifdef SSD_IMGRAM_CLEAR_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 58368;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clken = 1'b0;
    logic          reset_req = 1'b0;
    logic [AW-1:0] address = '0;
    logic          chipselect = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [3:0]    byteenable = '0;
    logic [DW-1:0] writedata = '0;

    logic [DW-1:0] readdata0, readdata1;
    logic          rdv0, rdv1, wait0, wait1, init0, init1;

    int testCount = 0;
    int failCount = 0;
    int cyc = 0;
    bit modelInit;
    logic [DW-1:0] modelMem [int];
    logic [DW-1:0] exp0 [int];
    logic [DW-1:0] exp1 [int];
    logic [DW-1:0] lastData0, lastData1;

    ssd_image_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .OUT_REG(0)) u0 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .readdata(readdata0), .readdatavalid(rdv0), .waitrequest(wait0), .init_done(init0)
    );

    ssd_image_ram #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .OUT_REG(1)) u1 (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata),
        .readdata(readdata1), .readdatavalid(rdv1), .waitrequest(wait1), .init_done(init1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] modelRead(input int a);
        if (a >= DEPTH) return '0;
        if (modelMem.exists(a)) return modelMem[a];
        return '0;
    endfunction

    // Compare both read ports against what the model scheduled for this cycle.
    task automatic checkPipes();
        checkOutput("rdvalid0", 32'(rdv0), 32'(exp0.exists(cyc)));
        if (exp0.exists(cyc)) begin
            checkOutput("rddata0", readdata0, exp0[cyc]);
            lastData0 = exp0[cyc];
            exp0.delete(cyc);
        end else begin
            checkOutput("rdhold0", readdata0, lastData0);
        end
        checkOutput("rdvalid1", 32'(rdv1), 32'(exp1.exists(cyc)));
        if (exp1.exists(cyc)) begin
            checkOutput("rddata1", readdata1, exp1[cyc]);
            lastData1 = exp1[cyc];
            exp1.delete(cyc);
        end else begin
            checkOutput("rdhold1", readdata1, lastData1);
        end
        checkOutput("initDone", 32'(init0), 32'(modelInit));
    endtask

    // One bus cycle: drive at negedge, model the edge, check at the next negedge.
    task automatic applyStimulus(input bit cs, input bit rd, input bit wr, input bit ce, input bit rr,
                                 input int a, input logic [3:0] be, input logic [DW-1:0] wd);
        bit expWait;
        bit acc;
        logic [DW-1:0] d;
        chipselect = cs; read = rd; write = wr; clken = ce; reset_req = rr;
        address = AW'(a); byteenable = be; writedata = wd;
        #1;
        expWait = !modelInit || !ce || rr;
        checkOutput("waitrequest0", 32'(wait0), 32'(expWait));
        checkOutput("waitrequest1", 32'(wait1), 32'(expWait));
        acc = cs && (rd || wr) && !expWait;
        @(posedge clk);
        cyc++;
        if (acc && wr) begin
            if (a < DEPTH) begin
                d = modelRead(a);
                for (int i = 0; i < 4; i++) if (be[i]) d[8*i +: 8] = wd[8*i +: 8];
                modelMem[a] = d;
            end
        end else if (acc && rd) begin
            d = modelRead(a);
            exp0[cyc]     = d;
            exp1[cyc + 1] = d;
        end
        @(negedge clk);
        checkPipes();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 1, 0, 0, 4'h0, '0);
    endtask

    // Assert reset (discarding in-flight reads), release it, and wait out the sweep if built.
    task automatic resetDut(input int abortAt);
        int n;
        reset = 1'b1;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1; reset_req = 1'b0;
        exp0.delete(); exp1.delete();
        lastData0 = '0; lastData1 = '0;
`ifdef SSD_IMGRAM_CLEAR_EN
        modelInit = 1'b0;
        modelMem.delete();
`else
        modelInit = 1'b1;
`endif
        #2;
        checkOutput("rstValid0", 32'(rdv0), 32'h0);
        checkOutput("rstValid1", 32'(rdv1), 32'h0);
        checkOutput("rstData0", readdata0, 32'h0);
        checkOutput("rstData1", readdata1, 32'h0);
        checkOutput("rstInit", 32'(init1), 32'(modelInit));
        checkOutput("rstWait", 32'(wait1), 32'(!modelInit));
        @(negedge clk);
        reset = 1'b0;
`ifdef SSD_IMGRAM_CLEAR_EN
        n = 0;
        while (!init0 && n < DEPTH + 20) begin
            if (abortAt != 0 && n == abortAt) return;
            @(posedge clk);
            cyc++;
            n++;
            @(negedge clk);
        end
        checkOutput("sweepLen", 32'(n), 32'(DEPTH));
        checkOutput("sweepInit1", 32'(init1), 32'h1);
        modelInit = 1'b1;
`else
        if (abortAt != 0) return;
`endif
    endtask

    initial begin
        int a;
        int r;
        @(negedge clk);
        resetDut(0);
`ifdef SSD_IMGRAM_CLEAR_EN
        resetDut(7);
        resetDut(0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, 0, 1, 0, i, 4'h0, '0);
        idle(3);
`endif
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, 1, 0, i, 4'hF, $urandom);
        // Byte-enable merge at address 5 expects 0x11BB33DD.
        applyStimulus(1, 0, 1, 1, 0, 5, 4'hF, 32'h11223344);
        applyStimulus(1, 0, 1, 1, 0, 5, 4'b0101, 32'hAABBCCDD);
        applyStimulus(1, 1, 0, 1, 0, 5, 4'h0, '0);
        idle(2);
        applyStimulus(1, 0, 1, 1, 0, 6, 4'h0, 32'hFFFFFFFF);
        applyStimulus(1, 1, 0, 1, 0, 6, 4'h0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 1, 0, i, 4'h0, '0);
        idle(3);
        applyStimulus(1, 0, 1, 1, 0, DEPTH, 4'hF, 32'h5A);
        applyStimulus(1, 1, 0, 1, 0, DEPTH, 4'h0, '0);
        applyStimulus(1, 1, 0, 1, 0, 0, 4'h0, '0);
        applyStimulus(1, 1, 0, 1, 0, 65535, 4'h0, '0);
        idle(2);
        applyStimulus(1, 1, 0, 1, 0, 3, 4'h0, '0);
        applyStimulus(1, 1, 0, 0, 0, 4, 4'h0, '0);
        applyStimulus(1, 1, 0, 0, 0, 4, 4'h0, '0);
        applyStimulus(1, 1, 0, 1, 0, 4, 4'h0, '0);
        applyStimulus(1, 1, 0, 1, 1, 8, 4'h0, '0);
        applyStimulus(1, 1, 0, 1, 0, 8, 4'h0, '0);
        idle(2);
        applyStimulus(1, 1, 1, 1, 0, 9, 4'hF, 32'hCAFEF00D);
        applyStimulus(1, 1, 0, 1, 0, 9, 4'h0, '0);
        applyStimulus(0, 1, 0, 1, 0, 9, 4'h0, '0);
        idle(2);
        applyStimulus(1, 1, 0, 1, 0, 1, 4'h0, '0);
        applyStimulus(1, 1, 0, 1, 0, 2, 4'h0, '0);
        resetDut(0);
        idle(3);
`ifdef SSD_IMGRAM_CLEAR_EN
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 1, 1, 0, i, 4'hF, $urandom);
`endif
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 75) a = $urandom_range(0, 15);
            else if (r < 92) a = DEPTH + $urandom_range(0, 2);
            else a = 65535;
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 2) == 0, $urandom_range(0, 4) != 0,
                          $urandom_range(0, 9) == 0, a, 4'($urandom), $urandom);
        end
        idle(4);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ssd_image_ram.md
# ssd_image_ram

Parametrised single-port on-chip image buffer with an Avalon-MM slave interface for the SSD Nios soft-core system. It replaces the fixed 8-bit, 58368-word frame memory and adds:
- configurable data width and depth;
- byte enables;
- pipelined reads with `readdatavalid`;
- flow control through `waitrequest`;
- defined handling of out-of-range addresses;
- an optional post-reset clear sweep.

It sits on the system interconnect as a frame store that is written by the CPU and read by display or processing masters.

## Interface
- `DATA_WIDTH`, 8, word width in bits; must be 8, 16 or 32.
- `DEPTH`, 58368, number of words.
- `ADDR_WIDTH`, 16, word-address width; requires 2^ADDR_WIDTH >= DEPTH.
- `OUT_REG`, 0, set to 1 to add one output register stage (read latency 1+OUT_REG).
- `INIT_FILE`, "ssd_image_ram.hex", initial contents; used only when the clear sweep is compiled out.

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `clken`  in  1  clock enable; when low, no new access is accepted.
- `reset_req`  in  1  reset-request hold-off; when high, no new access is accepted.
- `address`  in  ADDR_WIDTH  word address.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `byteenable`  in  DATA_WIDTH/8  per-byte write enable.
- `writedata`  in  DATA_WIDTH  write data.
- `readdata`  out  DATA_WIDTH  read data; valid only while `readdatavalid` is high.
- `readdatavalid`  out  1  one-cycle pulse per completed read.
- `waitrequest`  out  1  high means the request is not accepted this cycle.
- `init_done`  out  1  high once the memory is ready for traffic.

## Operation
- Accept condition: `chipselect & (read|write) & ~waitrequest`, sampled at the rising edge of `clk`.
- `waitrequest` = `~init_done | ~clken | reset_req`. It is a combinational function of registered state and the inputs.
- Write:
  - Only bytes with `byteenable[i]`=1 are updated; other bytes keep their value.
  - `byteenable`=0 is a legal no-op.
- Read:
  - One read is accepted per cycle, fully pipelined, and results return in order.
  - Reads already in flight complete even if `clken` drops or `reset_req` rises.
- `read` and `write` both high: the write is performed, the read is discarded, and no `readdatavalid` is generated.
- Out-of-range address (`address` >= DEPTH):
  - A write is dropped.
  - A read returns all zeros with a normal `readdatavalid`.
- Read-during-write:
  - A same-cycle read is impossible (a simultaneous request is handled as a write).
  - A read accepted in the cycle after a write to the same address returns the new data.
- State machine (`init_done` reflects the state):
  - `CLEAR`: a sweep counter writes zero to address 0..DEPTH-1, one word per cycle while `clken`=1 and `reset_req`=0. The sweep pauses otherwise. Leaves to `READY` after address DEPTH-1 is written.
  - `READY`: normal operation; the state is left only by `reset`.

## Timing
- Reset values:
  - `readdata`=0, `readdatavalid`=0.
  - `waitrequest`=1 when the sweep is compiled in.
  - `init_done`=0 with the sweep compiled in; 1 without it.
- Read accepted at edge N: `readdata` is valid and `readdatavalid`=1 in the cycle following edge N+OUT_REG. At all other times `readdatavalid`=0 and `readdata` holds its last value.
- Write accepted at edge N: the array is updated at edge N.
- Clear sweep: exactly DEPTH enabled cycles from reset deassertion. `init_done` rises in the cycle after the last clear write.
- `reset` asserted mid-operation:
  - All in-flight reads are discarded; no `readdatavalid` is generated for them.
  - With the sweep compiled in, the sweep restarts from address 0.
  - Without the sweep, array contents are not altered.

## Configuration
- Macro: `SSD_IMGRAM_CLEAR_EN`.
- Defined:
  - The `CLEAR` state and the sweep counter are built, and `INIT_FILE` is ignored.
  - After every reset the memory reads all zeros once `init_done`=1.
- Undefined:
  - There is no `CLEAR` state, the FSM sits in `READY`, and `init_done` is tied to 1.
  - The array is preloaded from `INIT_FILE` at configuration.
  - `waitrequest` = `~clken | reset_req`.

## Test plan
- Byte-enable write, DATA_WIDTH=32: write 0xAABBCCDD to address 5 with byteenable=4'b0101 over an initial value of 0x11223344, then read address 5 -> 0x11BB33DD, `readdatavalid` one cycle after acceptance (OUT_REG=0).
- Back-to-back reads, OUT_REG=1: read addresses 0,1,2 on consecutive cycles -> three consecutive `readdatavalid` pulses carrying the data in order, the first two cycles after the first acceptance.
- Out of range, DEPTH=58368: write 0x5A to address 58368, then read address 58368 -> 0x00 with `readdatavalid`=1; address 0 is unchanged.
- Flow control: drop `clken` while a read is in flight and another read is requested -> the in-flight read completes, the new read stalls with `waitrequest`=1 and is accepted on the first cycle after `clken`=1.
- With `SSD_IMGRAM_CLEAR_EN`, DEPTH=16:
  - After reset, `init_done` rises after 16 cycles and a read of any address returns 0.
  - Asserting `reset` at sweep cycle 7 restarts the sweep: `init_done` comes 16 cycles after reset release.
- Without the macro: `init_done`=1 and `waitrequest`=0 out of reset, and a read of address 0 returns the `INIT_FILE` word 0.
